button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Consumes a restartable cycle-count "interval achieved" flag to debounce one raw
//  asynchronous push-button/switch input. Sits between the FPGA pin and user logic:
//  synchronizes the pin, rejects bounce shorter than DEBOUNCE_CYCLES, and presents a
//  clean level plus single-cycle press/release pulses.
// PARAMETERS
//  DEBOUNCE_CYCLES    50000   cycles synchronized input must hold before accept; >=2
//  SYNC_STAGES        2       synchronizer flop depth; >=2
//  ACTIVE_LOW_INPUT   1       1: pin reads 0 when pressed (pull-up); inverted after sync
//  LONG_PRESS_CYCLES  1000000 held-press threshold (used only with long-press feature); >=2
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset (asserted at 0)
//  btn_raw     in   1  raw pin, asynchronous to clk
//  btn_level   out  1  debounced level, 1 = pressed
//  press       out  1  one-cycle pulse on accepted 0->1 of btn_level
//  release     out  1  one-cycle pulse on accepted 1->0 of btn_level
//  long_press  out  1  one-cycle pulse after LONG_PRESS_CYCLES held (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0, async): sync chain, state, counters, all outputs = 0; state=IDLE_LOW.
//    Sync flops reset to the released value (1 if ACTIVE_LOW_INPUT).
//  - sync_in = last sync stage, XOR ACTIVE_LOW_INPUT. Pin-to-sync_in = SYNC_STAGES cycles.
//  - States: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
//    IDLE_LOW : sync_in=1 -> WAIT_HIGH, timer restart (count=0, done=0).
//    WAIT_HIGH: sync_in=0 -> IDLE_LOW (bounce rejected, no pulse);
//               else done -> IDLE_HIGH, btn_level<=1, press<=1 for one cycle.
//    IDLE_HIGH: sync_in=0 -> WAIT_LOW, timer restart.
//    WAIT_LOW : sync_in=1 -> IDLE_HIGH (rejected); else done -> IDLE_LOW,
//               btn_level<=0, release<=1 for one cycle.
//  - Timer: count increments each cycle in WAIT_*; done = (count == DEBOUNCE_CYCLES-1);
//    count saturates at DEBOUNCE_CYCLES-1 (no wrap). Width $clog2(DEBOUNCE_CYCLES).
//  - Latency: sync_in must be stable for DEBOUNCE_CYCLES+1 consecutive samples; btn_level
//    changes exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after a clean pin edge.
//  - Bounce and done in the same cycle: bounce wins (reject), no pulse.
//  - press/release never both 1; never asserted during or in the cycle after reset.
//  - btn_level is registered; pulses registered, coincident with the btn_level change.
// CONFIGURATION
//  Macro BUTTON_DEBOUNCER_LONG_PRESS_EN:
//   defined : second counter runs in IDLE_HIGH from entry; at count==LONG_PRESS_CYCLES-1
//             long_press pulses once, then saturates; no repeat until re-entry to
//             IDLE_HIGH from WAIT_HIGH (rejected release glitch WAIT_LOW->IDLE_HIGH
//             does NOT restart it). Cleared on leaving to IDLE_LOW or reset.
//   undefined: no counter synthesized; long_press tied to 0 (port kept).
// STRUCTURE
//  - debounce_pkg: typedef enum logic [1:0] debounce_state_t {IDLE_LOW, WAIT_HIGH,
//    IDLE_HIGH, WAIT_LOW}; function to size counters ($clog2 with minimum 1).
//  - Sub-module debounce_timer #(COUNT_TARGET): async active-low reset, sync restart
//    and enable inputs, sticky saturating done output; instantiated once for the
//    debounce interval, and a second time for long press when the macro is defined.
//  - Top: synchronizer, FSM, pulse registers.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW_INPUT=0, LONG_PRESS_CYCLES=10)
//  1 Reset held 5 cycles, btn_raw=1 -> all outputs 0 throughout and 1 cycle after release.
//  2 Clean press: btn_raw 0->1 at cycle 0 -> btn_level=1 and press=1 at cycle 7 only,
//    press=0 at cycle 8; release symmetric with release pulse.
//  3 Bounce: btn_raw 1 for 3 cycles, 0 for 2, then 1 stable -> exactly one press,
//    7 cycles after last rising edge; no release pulse.
//  4 Glitch shorter than 5 synced samples while pressed -> btn_level stays 1, no pulses.
//  5 reset=0 mid WAIT_HIGH (count=2) -> outputs 0 immediately; after reset, stable
//    btn_raw=1 requires the full 7 cycles again.
//  6 Macro defined: hold 30 cycles -> one long_press exactly 10 cycles after press;
//    macro undefined -> long_press constant 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and helpers for the button debouncer.
// Holds the FSM state encoding and the counter sizing function used by
// both the debounce interval timer and the optional long-press timer.

package debounce_pkg;

    // Debouncer states: two stable levels, each with a qualifying wait state
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    // Counter width needed to hold values 0 .. target-1, never narrower than 1 bit
    function automatic int counter_width(input int target);
        int w;
        w = $clog2(target);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_timer.sv
// debounce_timer: restartable cycle counter with a sticky "interval achieved" flag.
// restart clears the count (and therefore done) on the next edge and has priority
// over enable. While enabled the count climbs to COUNT_TARGET-1 and then holds there,
// so done stays asserted until the next restart instead of wrapping around.

module debounce_timer
    import debounce_pkg::*;
#(
    parameter int COUNT_TARGET = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = counter_width(COUNT_TARGET);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(COUNT_TARGET - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, restarting on request and saturating at the last value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable && (count != LAST_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == LAST_COUNT);

endmodule : debounce_timer

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes one raw push-button pin and debounces it.
// The pin passes through a SYNC_STAGES-deep synchronizer, is optionally inverted
// (ACTIVE_LOW_INPUT) so that 1 always means pressed, and is then qualified by a
// four-state FSM driven by a restartable interval timer. A level change is accepted
// only after the synchronized input holds for DEBOUNCE_CYCLES+1 consecutive samples.
// Outputs btn_level, press and release_pulse are all registered; the pulses coincide
// with the btn_level change. The release pulse port is called release_pulse because
// "release" is a reserved word in SystemVerilog.
// Optional feature: define BUTTON_DEBOUNCER_LONG_PRESS_EN to build the long-press
// detector; otherwise long_press is tied low and no second counter exists.

module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int SYNC_STAGES       = 2,
    parameter bit ACTIVE_LOW_INPUT  = 1'b1,
    parameter int LONG_PRESS_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    // Reject parameter values the timers and synchronizer cannot honour
    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
            $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("button_debouncer: SYNC_STAGES must be at least 2");
        end
        if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press_cycles
            $error("button_debouncer: LONG_PRESS_CYCLES must be at least 2");
        end
    endgenerate

    // Synchronizer flops idle at the released pin value so reset never looks like a press
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ACTIVE_LOW_INPUT}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;

    debounce_state_t state;
    debounce_state_t next_state;

    logic level_next;
    logic press_next;
    logic release_next;
    logic deb_restart;
    logic deb_enable;
    logic deb_done;

    // Shift the asynchronous pin through the synchronizer chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= SYNC_IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_INPUT;

    debounce_timer #(
        .COUNT_TARGET (DEBOUNCE_CYCLES)
    ) u_debounce_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (deb_restart),
        .enable  (deb_enable),
        .done    (deb_done)
    );

    // Hold the current debouncer state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
        end else begin
            state <= next_state;
        end
    end

    // Decide the next state, timer control and next output values; a bounce in the
    // same cycle as done always wins so that a glitch can never be accepted
    always_comb begin
        next_state   = state;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        deb_restart  = 1'b0;
        deb_enable   = 1'b0;

        unique case (state)
            IDLE_LOW: begin
                level_next = 1'b0;
                if (sync_in) begin
                    next_state  = WAIT_HIGH;
                    deb_restart = 1'b1;
                end
            end
            WAIT_HIGH: begin
                deb_enable = 1'b1;
                if (!sync_in) begin
                    next_state = IDLE_LOW;
                end else if (deb_done) begin
                    next_state = IDLE_HIGH;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end
            end
            IDLE_HIGH: begin
                level_next = 1'b1;
                if (!sync_in) begin
                    next_state  = WAIT_LOW;
                    deb_restart = 1'b1;
                end
            end
            WAIT_LOW: begin
                deb_enable = 1'b1;
                if (sync_in) begin
                    next_state = IDLE_HIGH;
                end else if (deb_done) begin
                    next_state   = IDLE_LOW;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end
            end
            default: begin
                next_state = IDLE_LOW;
                level_next = 1'b0;
            end
        endcase
    end

    // Register the clean level and the single-cycle press/release pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            btn_level     <= level_next;
            press         <= press_next;
            release_pulse <= release_next;
        end
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN

    // Long-press timer restarts only on a real press or a real release, so a rejected
    // release glitch (WAIT_LOW back to IDLE_HIGH) does not re-arm the pulse
    logic long_restart;
    logic long_enable;
    logic long_done;
    logic long_fired;

    assign long_restart = ((state == WAIT_HIGH) && (next_state == IDLE_HIGH)) ||
                          ((state == WAIT_LOW)  && (next_state == IDLE_LOW));
    assign long_enable  = (state == IDLE_HIGH);

    debounce_timer #(
        .COUNT_TARGET (LONG_PRESS_CYCLES)
    ) u_long_press_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (long_restart),
        .enable  (long_enable),
        .done    (long_done)
    );

    // Emit one long_press pulse per accepted press once the hold threshold is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_press <= 1'b0;
            long_fired <= 1'b0;
        end else if (long_restart) begin
            long_press <= 1'b0;
            long_fired <= 1'b0;
        end else if (long_enable && long_done && !long_fired) begin
            long_press <= 1'b1;
            long_fired <= 1'b1;
        end else begin
            long_press <= 1'b0;
        end
    end

`else

    assign long_press = 1'b0;

`endif

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed self-checking bench for button_debouncer with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW_INPUT=0, LONG_PRESS_CYCLES=10.
// Inputs change 1 time unit after a rising edge and outputs are checked there too,
// so a pin change made after edge k first reaches the synchronizer at edge k+1 and
// btn_level is expected to change at edge k+7.

module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic btn_level;
    logic press;
    logic release_pulse;
    logic long_press;

    int checks_total  = 0;
    int checks_passed = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .SYNC_STAGES       (2),
        .ACTIVE_LOW_INPUT  (1'b0),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the raw pin and let the given number of edges pass
    task automatic applyStimulus(input logic raw, input int cycles);
        btn_raw = raw;
        tick(cycles);
    endtask

    // Compare every output against its hand-computed expected value
    task automatic checkOutput(input string tag, input logic exp_level, input logic exp_press,
                               input logic exp_release, input logic exp_long);
        checks_total++;
        assert (btn_level === exp_level) checks_passed++;
        else $error("[TB] FAIL %s btn_level: got %b expected %b", tag, btn_level, exp_level);
        checks_total++;
        assert (press === exp_press) checks_passed++;
        else $error("[TB] FAIL %s press: got %b expected %b", tag, press, exp_press);
        checks_total++;
        assert (release_pulse === exp_release) checks_passed++;
        else $error("[TB] FAIL %s release_pulse: got %b expected %b", tag, release_pulse, exp_release);
        checks_total++;
        assert (long_press === exp_long) checks_passed++;
        else $error("[TB] FAIL %s long_press: got %b expected %b", tag, long_press, exp_long);
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b1;

        // Reset held with the pin pressed: everything stays low, also one cycle after
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        tick(1);
        checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 10);
        checkOutput("idle_low", 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean press: level and press appear 7 edges after the pin change
        applyStimulus(1'b1, 6);
        checkOutput("press_early", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("press_edge", 1'b1, 1'b1, 1'b0, 1'b0);

        // Long hold: long_press pulses exactly 10 cycles after press when enabled
        for (int i = 1; i < 30; i++) begin
            tick(1);
            checkOutput("hold", 1'b1, 1'b0, 1'b0, LONG_EN && (i == 10));
        end

        // Release glitch of 4 synced samples is rejected and does not re-arm long press
        applyStimulus(1'b0, 4);
        btn_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checkOutput("glitch", 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Clean release: symmetric timing with a single release pulse
        applyStimulus(1'b0, 6);
        checkOutput("release_early", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("release_edge", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("release_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce: 3 high, 2 low, then stable high gives one press 7 edges after last rise
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("bounce_high", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checkOutput("bounce_low", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checkOutput("bounce_settle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick(1);
        checkOutput("bounce_press", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("bounce_press_after", 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 7);
        checkOutput("bounce_release", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("bounce_release_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in WAIT_HIGH with count at 2, then the full qualification is needed again
        applyStimulus(1'b1, 5);
        reset = 1'b0;
        #1;
        checkOutput("reset_mid_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b1;
        tick(6);
        checkOutput("rearm_early", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("rearm_press", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("rearm_press_after", 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while pressed clears the level without waiting for a clock
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_pressed", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("async_reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_button_debouncer
